axi_wdata_joiner: RTL and testbench

AXI_WDATA_JOINER -- requirements
Module: axi_wdata_joiner

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_bresp_fifo.sv | 63 ++++++
 rtl/axi_wdata_joiner.sv | 109 ++++++++++
 tb/tb_axi_wdata_joiner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants for the write-data joiner: response codes, bus widths
// and the beat limit that separates a legal burst from an overflowing one.
package axi_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAX_BEATS  = 256;
  localparam int BEAT_CNT_W = 9;

  typedef logic [1:0] bresp_t;
  localparam bresp_t BRESP_OKAY   = 2'b00;
  localparam bresp_t BRESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_bresp_fifo.sv
// Small synchronous FIFO holding pending AXI B responses, with a registered
// occupancy count; pointers wrap naturally because DEPTH is a power of two.
module axi_bresp_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head reads as zero while empty so the B channel is clean after reset.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_count_bound: assert property (@(posedge clk) count_q <= FULL_CNT);
endmodule

// File: rtl/axi_wdata_joiner.sv
// Joins an upstream address-beat stream with the AXI W channel into single
// memory write pulses, and generates one B response per burst.
module axi_wdata_joiner #(
  parameter  int BRESP_DEPTH = 4,
  localparam int ADDR_WIDTH  = axi_pkg::ADDR_WIDTH,
  localparam int DATA_WIDTH  = axi_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   i_next_addr_data,
  input  logic                    i_next_addr_valid,
  output logic                    i_next_addr_ready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    i_wready,
  output logic [1:0]              i_bresp,
  output logic                    i_bvalid,
  input  logic                    i_bready,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-3:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb
);
  import axi_pkg::*;

  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX = BEAT_CNT_W'(MAX_BEATS);

  logic                    resp_full, resp_empty;
  logic                    fire, push, pop, beat_err;
  bresp_t                  push_resp, head_resp;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-3:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH/8-1:0] mem_wstrb_q;

  // Each ready looks only at the other channel's valid, so neither side waits on itself.
  assign i_wready          = i_next_addr_valid && !resp_full && !reset;
  assign i_next_addr_ready = i_wvalid && !resp_full && !reset;
  assign fire              = i_next_addr_valid && i_wvalid && !resp_full && !reset;

  assign beat_err  = ovf_q || (beat_cnt_q == BEAT_MAX);
  assign push      = fire && i_wlast;
  assign push_resp = beat_err ? BRESP_SLVERR : BRESP_OKAY;
  assign pop       = i_bvalid && i_bready;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    ovf_d      = ovf_q;
    if (fire) begin
      if (i_wlast) begin
        beat_cnt_d = '0;
        ovf_d      = 1'b0;
      end else if (beat_cnt_q == BEAT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
      mem_we_q   <= fire;
      if (fire) begin
        mem_addr_q  <= i_next_addr_data[ADDR_WIDTH-1:2];
        mem_wdata_q <= i_wdata;
        mem_wstrb_q <= i_wstrb;
      end
    end
  end

  axi_bresp_fifo #(
    .WIDTH (2),
    .DEPTH (BRESP_DEPTH)
  ) u_bresp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_resp),
    .pop_i       (pop),
    .head_o      (head_resp),
    .empty_o     (resp_empty),
    .full_o      (resp_full)
  );

  assign i_bvalid    = !resp_empty;
  assign i_bresp     = head_resp;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;

  a_b_stable: assert property (@(posedge clk) disable iff (reset)
    (i_bvalid && !i_bready) |=> (i_bvalid && $stable(i_bresp)));
  a_beat_bound: assert property (@(posedge clk) beat_cnt_q <= BEAT_MAX);
endmodule

// File: tb/tb_axi_wdata_joiner.sv
// Scoreboard bench for axi_wdata_joiner: drivers queue expected memory writes
// and B responses, a negedge monitor pops and compares them.
module tb_axi_wdata_joiner;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] i_next_addr_data;
  logic        i_next_addr_valid;
  logic        i_next_addr_ready;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        i_wlast;
  logic        i_wvalid;
  logic        i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid;
  logic        i_bready;
  logic        o_mem_we;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;

  int checks = 0;
  int errors = 0;
  logic [45:0] exp_mem_q[$];
  logic [1:0]  exp_resp_q[$];
  logic [45:0] mon_mem;
  logic [1:0]  mon_resp;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  axi_wdata_joiner #(.BRESP_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_next_addr_data  (i_next_addr_data),
    .i_next_addr_valid (i_next_addr_valid),
    .i_next_addr_ready (i_next_addr_ready),
    .i_wdata           (i_wdata),
    .i_wstrb           (i_wstrb),
    .i_wlast           (i_wlast),
    .i_wvalid          (i_wvalid),
    .i_wready          (i_wready),
    .i_bresp           (i_bresp),
    .i_bvalid          (i_bvalid),
    .i_bready          (i_bready),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .o_mem_wstrb       (o_mem_wstrb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every memory write and every B handshake against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_mem_we) begin
        if (exp_mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got addr 0x%0h data 0x%0h, expected no write", o_mem_addr, o_mem_wdata);
        end else begin
          mon_mem = exp_mem_q.pop_front();
          check("mem_write", {18'd0, o_mem_addr, o_mem_wdata, o_mem_wstrb}, {18'd0, mon_mem});
        end
      end
      if (i_bvalid && i_bready) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got bresp %0d, expected no response", i_bresp);
        end else begin
          mon_resp = exp_resp_q.pop_front();
          check("bresp", {62'd0, i_bresp}, {62'd0, mon_resp});
        end
      end
    end
  end

  // Present one beat and wait (bounded) for it to fire; called at posedge+1.
  task automatic beat(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic last, input logic resp_en, input logic [1:0] resp);
    bit done;
    done = 1'b0;
    i_next_addr_data  = a;
    i_wdata           = d;
    i_wstrb           = s;
    i_wlast           = last;
    i_next_addr_valid = 1'b1;
    i_wvalid          = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (i_wready && i_next_addr_ready) begin
        exp_mem_q.push_back({a[11:2], d, s});
        if (last && resp_en) exp_resp_q.push_back(resp);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got no fire for addr 0x%0h, expected fire within 50 cycles", a);
    end
    @(posedge clk); #1;
    i_next_addr_valid = 1'b0;
    i_wvalid          = 1'b0;
    i_wlast           = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_next_addr_data = '0; i_next_addr_valid = 1'b0;
    i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0;
    i_bready = 1'b1;
    idle(3);

    // Reset state, and readies held low while reset with both valids up.
    check("rst_bvalid", {63'd0, i_bvalid}, 64'd0);
    check("rst_bresp",  {62'd0, i_bresp}, 64'd0);
    check("rst_we",     {63'd0, o_mem_we}, 64'd0);
    check("rst_addr",   {54'd0, o_mem_addr}, 64'd0);
    check("rst_wdata",  {32'd0, o_mem_wdata}, 64'd0);
    check("rst_wstrb",  {60'd0, o_mem_wstrb}, 64'd0);
    i_next_addr_valid = 1'b1; i_wvalid = 1'b1; #1;
    check("rst_readies", {62'd0, i_wready, i_next_addr_ready}, 64'd0);
    i_next_addr_valid = 1'b0; i_wvalid = 1'b0;
    idle(1);
    reset = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Single beat with one-cycle write latency.
    beat(12'h010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, OKAY);
    check("single_we",   {63'd0, o_mem_we}, 64'd1);
    check("single_addr", {54'd0, o_mem_addr}, 64'h004);
    idle(3);

    // Zero-strobe beat still writes.
    beat(12'h020, 32'h12345678, 4'h0, 1'b1, 1'b1, OKAY);
    check("zstrb_we",    {63'd0, o_mem_we}, 64'd1);
    check("zstrb_wstrb", {60'd0, o_mem_wstrb}, 64'd0);
    idle(3);

    // W ahead of address by two cycles.
    i_wdata = 32'hA0; i_wstrb = 4'hF; i_wlast = 1'b0; i_wvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("wfirst_wready", {63'd0, i_wready}, 64'd0);
      check("wfirst_aready", {63'd0, i_next_addr_ready}, 64'd1);
      check("wfirst_we",     {63'd0, o_mem_we}, 64'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      beat(12'h100 + 12'(i * 4), 32'hA0 + 32'(i), 4'hF, (i == 3), 1'b1, OKAY);
    idle(3);

    // Full response FIFO stalls the fifth single-beat burst.
    i_bready = 1'b0;
    for (int i = 0; i < 4; i++)
      beat(12'h200 + 12'(i * 4), 32'hB0 + 32'(i), 4'h3, 1'b1, 1'b1, OKAY);
    i_next_addr_data = 12'h210; i_wdata = 32'hB4; i_wstrb = 4'hC; i_wlast = 1'b1;
    i_next_addr_valid = 1'b1; i_wvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_readies", {62'd0, i_wready, i_next_addr_ready}, 64'd0);
      check("full_bvalid",  {62'd0, i_bvalid, i_bresp == OKAY}, 64'd3);
    end
    @(posedge clk); #1;
    i_bready = 1'b1;
    @(posedge clk); #1;
    i_bready = 1'b0;
    beat(12'h210, 32'hB4, 4'hC, 1'b1, 1'b1, OKAY);
    i_bready = 1'b1;
    idle(8);

    // 257 beats without wlast, then wlast on beat 258: overflow response.
    for (int i = 0; i < 257; i++)
      beat(12'(i * 4), 32'hC000 + 32'(i), 4'hF, 1'b0, 1'b0, OKAY);
    beat(12'h408, 32'hC0FF, 4'hF, 1'b1, 1'b1, SLVERR);
    beat(12'h500, 32'hD0, 4'hF, 1'b0, 1'b0, OKAY);
    beat(12'h504, 32'hD1, 4'hF, 1'b1, 1'b1, OKAY);
    idle(3);

    // Reset during beat 3 of an 8-beat burst with one queued response.
    i_bready = 1'b0;
    beat(12'h300, 32'hE0, 4'hF, 1'b1, 1'b0, OKAY);
    beat(12'h340, 32'hE1, 4'hF, 1'b0, 1'b0, OKAY);
    beat(12'h344, 32'hE2, 4'hF, 1'b0, 1'b0, OKAY);
    reset = 1'b1;
    i_next_addr_data = 12'h348; i_wdata = 32'hE3; i_wstrb = 4'hF; i_wlast = 1'b0;
    i_next_addr_valid = 1'b1; i_wvalid = 1'b1;
    @(negedge clk);
    check("midrst_readies", {62'd0, i_wready, i_next_addr_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_bvalid", {63'd0, i_bvalid}, 64'd0);
    check("midrst_we",     {63'd0, o_mem_we}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    i_next_addr_valid = 1'b0; i_wvalid = 1'b0;
    i_bready = 1'b1;
    idle(1);
    beat(12'h380, 32'hF0, 4'hF, 1'b0, 1'b0, OKAY);
    beat(12'h384, 32'hF1, 4'hF, 1'b1, 1'b1, OKAY);
    idle(3);

    // Push and pop in the same cycle at count 1: no gap on bvalid.
    i_bready = 1'b0;
    beat(12'h400, 32'h11, 4'hF, 1'b1, 1'b1, OKAY);
    i_bready = 1'b1;
    beat(12'h404, 32'h22, 4'hF, 1'b1, 1'b1, OKAY);
    check("pushpop_bvalid", {63'd0, i_bvalid}, 64'd1);
    @(negedge clk);
    check("pushpop_bvalid_n", {63'd0, i_bvalid}, 64'd1);
    @(posedge clk); #1;

    for (int n = 0; n < 20 && (exp_mem_q.size() != 0 || exp_resp_q.size() != 0); n++)
      idle(1);
    check("mem_queue_empty",  64'(exp_mem_q.size()), 64'd0);
    check("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);
    check("end_bvalid", {63'd0, i_bvalid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
